// File: rtl/panel_mem_ctrl.sv
// Front-panel memory controller: keys and switches edit an address/data pair, then issue clear/write/read.
// Optional key debounce is built in when PANEL_DEBOUNCE_EN is defined.
module panel_mem_ctrl #(
  parameter int unsigned NUM_SW  = 4,
  parameter int unsigned ADDR_W  = 25,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned DEB_CYC = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key0,
  input  logic                key1,
  input  logic [NUM_SW-1:0]   switches,
  input  logic                mem_done,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_clr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [1:0]          mode_out,
  output logic [1:0]          stage_level,
  output logic [4*NUM_SW-1:0] display_data,
  output logic                io_done,
  output logic                err
);

  localparam int unsigned PAGE_W = 4 * NUM_SW;
  localparam int unsigned SYNC_W = NUM_SW + 2;
  localparam int unsigned A_DIG  = (ADDR_W + 3) / 4;
  localparam int unsigned D_DIG  = (DATA_W + 3) / 4;
  localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  if (ADDR_W <= PAGE_W || ADDR_W > 2 * PAGE_W) begin : gBadAddrW
    $error("panel_mem_ctrl: ADDR_W out of legal range");
  end
  if (DATA_W > PAGE_W || TIMEOUT == 0 || DEB_CYC == 0) begin : gBadParam
    $error("panel_mem_ctrl: illegal DATA_W, TIMEOUT or DEB_CYC");
  end

  typedef enum logic [2:0] {CLEAR, WRITE, READ, ADDR_LO, ADDR_HI, DATA, ISSUE, WAIT} stateT;

  // Two-flop synchroniser plus one delayed copy for rising-edge detection.
  logic [SYNC_W-1:0] syncMeta, syncLvl, syncPrev;
  always_ff @(posedge clk) begin
    if (rst) begin
      syncMeta <= '0;
      syncLvl  <= '0;
      syncPrev <= '0;
    end else begin
      syncMeta <= {switches, key1, key0};
      syncLvl  <= syncMeta;
      syncPrev <= syncLvl;
    end
  end

  logic [NUM_SW-1:0] swEvt;
  logic [1:0]        keyEvt;
  logic              key0Evt, key1Evt;

  assign swEvt = syncLvl[SYNC_W-1:2] & ~syncPrev[SYNC_W-1:2];

`ifdef PANEL_DEBOUNCE_EN
  localparam int unsigned DEB_W = $clog2(DEB_CYC + 1);

  for (genvar k = 0; k < 2; k++) begin : gDeb
    logic [DEB_W-1:0] stableCnt;
    logic             debLvl, debEvt, same;

    assign same      = (syncLvl[k] == syncPrev[k]);
    assign keyEvt[k] = debEvt;

    // stableCnt holds how many consecutive cycles the current level has been seen.
    always_ff @(posedge clk) begin
      if (rst) begin
        stableCnt <= '0;
        debLvl    <= 1'b0;
        debEvt    <= 1'b0;
      end else begin
        debEvt <= 1'b0;
        if (!same) stableCnt <= DEB_W'(1);
        else if (stableCnt != DEB_W'(DEB_CYC)) stableCnt <= stableCnt + DEB_W'(1);
        if (same && stableCnt >= DEB_W'(DEB_CYC - 1) && debLvl != syncLvl[k]) begin
          debLvl <= syncLvl[k];
          debEvt <= syncLvl[k];
        end
      end
    end
  end
`else
  assign keyEvt = syncLvl[1:0] & ~syncPrev[1:0];
`endif

  assign key0Evt = keyEvt[0];
  assign key1Evt = keyEvt[1];

  stateT state, parent;
  logic  inLo, inHi, inData;
  assign inLo   = (state == ADDR_LO);
  assign inHi   = (state == ADDR_HI);
  assign inData = (state == DATA);

  // Digit incrementers; a partial top digit wraps within its own width, absent digits never exist.
  logic [ADDR_W-1:0] addrNext;
  logic [DATA_W-1:0] wdataNext;

  for (genvar d = 0; d < A_DIG; d++) begin : gAddrDig
    localparam int unsigned LO = 4 * d;
    localparam int unsigned W  = (ADDR_W - LO >= 4) ? 4 : ADDR_W - LO;
    logic hit;
    if (d < NUM_SW) begin : gLoPage
      assign hit = inLo & swEvt[d];
    end else begin : gHiPage
      assign hit = inHi & swEvt[d - NUM_SW];
    end
    assign addrNext[LO +: W] = mem_addr[LO +: W] + W'(hit);
  end

  for (genvar d = 0; d < D_DIG; d++) begin : gDataDig
    localparam int unsigned LO = 4 * d;
    localparam int unsigned W  = (DATA_W - LO >= 4) ? 4 : DATA_W - LO;
    assign wdataNext[LO +: W] = mem_wdata[LO +: W] + W'(inData & swEvt[d]);
  end

  function automatic logic [1:0] modeCode(input stateT s);
    case (s)
      CLEAR:   modeCode = 2'b00;
      WRITE:   modeCode = 2'b10;
      READ:    modeCode = 2'b01;
      default: modeCode = 2'b11;
    endcase
  endfunction

  logic [DATA_W-1:0] rdata, rdataNext;
  logic [WAIT_W-1:0] waitCnt, waitCntNext;
  stateT             stateNext, parentNext;
  logic              reqNext, weNext, clrNext, doneNext, errNext;
  logic [1:0]        modeNext, stageNext;
  logic [PAGE_W-1:0] dispNext;

  // Next-state and next-output logic; key0 is tested first so it wins over key1.
  always_comb begin
    stateNext   = state;
    parentNext  = parent;
    reqNext     = mem_req;
    weNext      = mem_we;
    clrNext     = mem_clr;
    doneNext    = 1'b0;
    errNext     = err;
    rdataNext   = rdata;
    waitCntNext = waitCnt;
    modeNext    = 2'b11;
    stageNext   = 2'b00;
    dispNext    = PAGE_W'(rdata);

    if (key0Evt) errNext = 1'b0;

    case (state)
      CLEAR:
        if (key0Evt) stateNext = WRITE;
        else if (key1Evt) begin
          stateNext  = ISSUE;
          parentNext = CLEAR;
        end
      WRITE:
        if (key0Evt) stateNext = READ;
        else if (key1Evt) begin
          stateNext  = ADDR_LO;
          parentNext = WRITE;
        end
      READ:
        if (key0Evt) stateNext = CLEAR;
        else if (key1Evt) begin
          stateNext  = ADDR_LO;
          parentNext = READ;
        end
      ADDR_LO:
        if (key0Evt) stateNext = parent;
        else if (key1Evt) stateNext = ADDR_HI;
      ADDR_HI:
        if (key0Evt) stateNext = parent;
        else if (key1Evt) stateNext = (parent == WRITE) ? DATA : ISSUE;
      DATA:
        if (key0Evt) stateNext = parent;
        else if (key1Evt) stateNext = ISSUE;
      ISSUE: begin
        stateNext   = WAIT;
        waitCntNext = '0;
      end
      WAIT:
        if (mem_done) begin
          stateNext = parent;
          reqNext   = 1'b0;
          weNext    = 1'b0;
          clrNext   = 1'b0;
          doneNext  = 1'b1;
          if (parent == READ) rdataNext = mem_rdata;
        end else if (waitCnt == WAIT_W'(TIMEOUT - 1)) begin
          stateNext = parent;
          reqNext   = 1'b0;
          weNext    = 1'b0;
          clrNext   = 1'b0;
          errNext   = 1'b1;
        end else begin
          waitCntNext = waitCnt + WAIT_W'(1);
        end
      default: stateNext = CLEAR;
    endcase

    if (stateNext == ISSUE) begin
      reqNext = 1'b1;
      weNext  = (parentNext == WRITE);
      clrNext = (parentNext == CLEAR);
    end

    // Edit stages show the parent mode; the display follows the page being edited.
    case (stateNext)
      ADDR_LO: begin
        modeNext  = modeCode(parentNext);
        stageNext = 2'b01;
        dispNext  = addrNext[PAGE_W-1:0];
      end
      ADDR_HI: begin
        modeNext  = modeCode(parentNext);
        stageNext = 2'b10;
        dispNext  = PAGE_W'(addrNext[ADDR_W-1:PAGE_W]);
      end
      DATA: begin
        modeNext  = modeCode(parentNext);
        stageNext = 2'b11;
        dispNext  = PAGE_W'(wdataNext);
      end
      default: begin
        modeNext = modeCode(stateNext);
        dispNext = PAGE_W'(rdataNext);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CLEAR;
      parent       <= CLEAR;
      waitCnt      <= '0;
      rdata        <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_clr      <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mode_out     <= 2'b00;
      stage_level  <= 2'b00;
      display_data <= '0;
      io_done      <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= stateNext;
      parent       <= parentNext;
      waitCnt      <= waitCntNext;
      rdata        <= rdataNext;
      mem_req      <= reqNext;
      mem_we       <= weNext;
      mem_clr      <= clrNext;
      mem_addr     <= addrNext;
      mem_wdata    <= wdataNext;
      mode_out     <= modeNext;
      stage_level  <= stageNext;
      display_data <= dispNext;
      io_done      <= doneNext;
      err          <= errNext;
    end
  end

endmodule

// File: tb/tb_panel_mem_ctrl.sv
// Directed self-checking bench for panel_mem_ctrl: write, read, wrap, timeout, clear, key priority, reset.
module tb_panel_mem_ctrl;

  localparam int unsigned NUM_SW  = 4;
  localparam int unsigned ADDR_W  = 25;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 1023;
  localparam int unsigned DEB_CYC = 8;
`ifdef PANEL_DEBOUNCE_EN
  localparam int HOLD = 16;
`else
  localparam int HOLD = 4;
`endif

  logic                clk = 1'b0;
  logic                rst, key0, key1, mem_done;
  logic [NUM_SW-1:0]   switches;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_req, mem_we, mem_clr, io_done, err;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [1:0]          mode_out, stage_level;
  logic [4*NUM_SW-1:0] display_data;

  int nChk = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  panel_mem_ctrl #(
    .NUM_SW(NUM_SW), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .DEB_CYC(DEB_CYC)
  ) dut (
    .clk(clk), .rst(rst), .key0(key0), .key1(key1), .switches(switches),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_clr(mem_clr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mode_out(mode_out),
    .stage_level(stage_level), .display_data(display_data), .io_done(io_done), .err(err)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pressKeys(input logic k0, input logic k1);
    key0 = k0;
    key1 = k1;
    tick(HOLD);
    key0 = 1'b0;
    key1 = 1'b0;
    tick(HOLD);
  endtask

  task automatic pressSw(input int i, input int n);
    for (int r = 0; r < n; r++) begin
      switches[i] = 1'b1;
      tick(4);
      switches[i] = 1'b0;
      tick(4);
    end
  endtask

  task automatic pulseDone();
    mem_done = 1'b1;
    tick(1);
    mem_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; key0 = 1'b0; key1 = 1'b0; switches = '0;
    mem_done = 1'b0; mem_rdata = '0;
    tick(3);
    rst = 1'b0;
    tick(1);

    chk("rst_mode",  32'(mode_out),     32'h0);
    chk("rst_stage", 32'(stage_level),  32'h0);
    chk("rst_req",   32'({mem_req, mem_we, mem_clr, io_done, err}), 32'h0);
    chk("rst_addr",  32'(mem_addr),     32'h0);
    chk("rst_disp",  32'(display_data), 32'h0);

    // Write transaction
    pressKeys(1'b1, 1'b0);
    chk("wr_mode", 32'(mode_out), 32'h2);
    pressKeys(1'b0, 1'b1);
    chk("wr_stage_lo", 32'(stage_level), 32'h1);
    pressSw(0, 3);
    pressSw(3, 1);
    chk("wr_disp_lo", 32'(display_data), 32'h1003);
    pressKeys(1'b0, 1'b1);
    chk("wr_stage_hi", 32'(stage_level), 32'h2);
    pressSw(0, 1);
    chk("wr_disp_hi", 32'(display_data), 32'h0001);
    pressKeys(1'b0, 1'b1);
    chk("wr_stage_data", 32'(stage_level), 32'h3);
    pressSw(1, 2);
    chk("wr_disp_data", 32'(display_data), 32'h0020);
    pressKeys(1'b0, 1'b1);
    chk("wr_req",   32'(mem_req),   32'h1);
    chk("wr_we",    32'(mem_we),    32'h1);
    chk("wr_clr",   32'(mem_clr),   32'h0);
    chk("wr_addr",  32'(mem_addr),  32'h0011003);
    chk("wr_wdata", 32'(mem_wdata), 32'h0020);
    chk("wr_mode_busy", 32'(mode_out), 32'h3);
    tick(5);
    chk("wr_req_held", 32'(mem_req), 32'h1);
    pulseDone();
    chk("wr_iodone", 32'(io_done),  32'h1);
    chk("wr_req_off", 32'(mem_req), 32'h0);
    chk("wr_mode_ret", 32'(mode_out), 32'h2);
    tick(1);
    chk("wr_iodone_pulse", 32'(io_done), 32'h0);

    // Read transaction from a fresh reset
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst2_addr", 32'(mem_addr), 32'h0);
    pressKeys(1'b1, 1'b0);
    pressKeys(1'b1, 1'b0);
    chk("rd_mode", 32'(mode_out), 32'h1);
    pressKeys(1'b0, 1'b1);
    pressSw(0, 5);
    chk("rd_disp_lo", 32'(display_data), 32'h0005);
    pressKeys(1'b0, 1'b1);
    pressKeys(1'b0, 1'b1);
    chk("rd_req",  32'(mem_req),  32'h1);
    chk("rd_we",   32'({mem_we, mem_clr}), 32'h0);
    chk("rd_addr", 32'(mem_addr), 32'h0000005);
    mem_rdata = 16'hBEEF;
    pulseDone();
    mem_rdata = '0;
    chk("rd_iodone", 32'(io_done), 32'h1);
    chk("rd_disp",   32'(display_data), 32'hBEEF);
    chk("rd_mode_ret", 32'(mode_out), 32'h1);
    tick(1);
    mem_rdata = 16'h1111;
    pulseDone();
    mem_rdata = '0;
    chk("stray_done_iodone", 32'(io_done), 32'h0);
    chk("stray_done_disp", 32'(display_data), 32'hBEEF);

    // High-page wrap and truncation
    pressKeys(1'b0, 1'b1);
    pressKeys(1'b0, 1'b1);
    chk("wrap_stage", 32'(stage_level), 32'h2);
    pressSw(0, 17);
    pressSw(2, 3);
    pressSw(3, 1);
    chk("wrap_addr", 32'(mem_addr), 32'h1010005);
    chk("wrap_disp", 32'(display_data), 32'h0101);
    pressKeys(1'b1, 1'b0);
    chk("abort_mode",  32'(mode_out), 32'h1);
    chk("abort_stage", 32'(stage_level), 32'h0);
    chk("abort_addr",  32'(mem_addr), 32'h1010005);
    chk("abort_disp",  32'(display_data), 32'hBEEF);
    pressSw(1, 1);
    chk("mode_sw_ignored", 32'(mem_addr), 32'h1010005);

    // Timeout
    pressKeys(1'b0, 1'b1);
    pressKeys(1'b0, 1'b1);
    pressKeys(1'b0, 1'b1);
    chk("to_req", 32'(mem_req), 32'h1);
    for (int c = 0; c < 1100 && mem_req; c++) tick(1);
    chk("to_req_off", 32'(mem_req), 32'h0);
    chk("to_err",     32'(err),     32'h1);
    chk("to_mode",    32'(mode_out), 32'h1);
    chk("to_iodone",  32'(io_done),  32'h0);
    pressKeys(1'b1, 1'b0);
    chk("to_err_clr", 32'(err), 32'h0);
    chk("to_mode_adv", 32'(mode_out), 32'h0);

    // Clear transaction must not capture read data
    mem_rdata = 16'h1234;
    pressKeys(1'b0, 1'b1);
    chk("clr_req", 32'({mem_req, mem_we, mem_clr}), 32'h5);
    chk("clr_mode_busy", 32'(mode_out), 32'h3);
    pulseDone();
    mem_rdata = '0;
    chk("clr_iodone", 32'(io_done), 32'h1);
    chk("clr_mode", 32'(mode_out), 32'h0);
    chk("clr_disp", 32'(display_data), 32'hBEEF);

    // key0 wins over a simultaneous key1
    pressKeys(1'b1, 1'b0);
    chk("sim_pre", 32'(mode_out), 32'h2);
    pressKeys(1'b1, 1'b1);
    chk("sim_mode",  32'(mode_out), 32'h1);
    chk("sim_stage", 32'(stage_level), 32'h0);

    // Reset during WAIT
    pressKeys(1'b0, 1'b1);
    pressKeys(1'b0, 1'b1);
    pressKeys(1'b0, 1'b1);
    chk("rstw_req_pre", 32'(mem_req), 32'h1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rstw_req",  32'(mem_req),  32'h0);
    chk("rstw_mode", 32'(mode_out), 32'h0);
    chk("rstw_addr", 32'(mem_addr), 32'h0);
    chk("rstw_disp", 32'(display_data), 32'h0);
    pulseDone();
    chk("rstw_late_done", 32'(io_done), 32'h0);
    chk("rstw_late_mode", 32'(mode_out), 32'h0);

`ifdef PANEL_DEBOUNCE_EN
    // Short bounce produces nothing; a stable press advances once
    key0 = 1'b1;
    tick(3);
    key0 = 1'b0;
    tick(16);
    chk("deb_bounce", 32'(mode_out), 32'h0);
    key0 = 1'b1;
    tick(16);
    chk("deb_stable", 32'(mode_out), 32'h2);
    key0 = 1'b0;
    tick(16);
    chk("deb_once", 32'(mode_out), 32'h2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChk, nErr);
    $finish;
  end

endmodule
